// File: rtl/signed_addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : signed_addsub_pkg
//  Purpose  : Shared constants and helpers for the signed add/sub pipeline.
//             Holds the op encoding and the saturation limit functions used
//             when SIGNED_ADDSUB_SAT_EN is defined.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package signed_addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Largest positive two's complement value of the given width,
    // returned in a 64-bit container. Callers slice the low bits.
    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Most negative two's complement value of the given width. The low
    // 'width' bits are 1 followed by zeros.
    function automatic logic [63:0] sat_min(input int width);
        return ~((64'd1 << (width - 1)) - 64'd1);
    endfunction

endpackage : signed_addsub_pkg
`default_nettype wire

// File: rtl/signed_addsub_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : signed_addsub_pipe_if
//  Purpose  : Operand/result handshake bundle for signed_addsub_pipe.
//  Signals  : in_valid/in_ready/in_a/in_b/in_op   - operand channel
//             out_valid/out_ready/out_sum/out_ovf  - result channel
//             out_sat (only with SIGNED_ADDSUB_SAT_EN) - saturated result
//  Modports : master - operand source / result consumer side
//             slave  - the pipeline itself
//  Revision : 1.0 - initial release
// ============================================================================
interface signed_addsub_pipe_if #(
    parameter int WIDTH = 4
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
    logic             out_ovf;
`ifdef SIGNED_ADDSUB_SAT_EN
    logic [WIDTH-1:0] out_sat;
`endif

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
`ifdef SIGNED_ADDSUB_SAT_EN
        , input out_sat
`endif
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
`ifdef SIGNED_ADDSUB_SAT_EN
        , output out_sat
`endif
    );

endinterface : signed_addsub_pipe_if
`default_nettype wire

// File: rtl/signed_addsub_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_pipe_stage
//  Purpose  : One elastic register slice. When 'adv' is high the slice takes
//             in_valid, and takes in_data only if in_valid is high, so the
//             data register keeps its last value across bubbles.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             adv                   - slice may load this cycle
//             in_valid, in_data     - upstream contents
//             out_valid, out_data   - registered contents
//  Revision : 1.0 - initial release
// ============================================================================
module addsub_pipe_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    logic          valid_d, valid_q;
    logic [DW-1:0] data_d,  data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (adv) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule : addsub_pipe_stage
`default_nettype wire

// File: rtl/signed_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : signed_addsub_pipe
//  Purpose  : Two-stage pipelined signed adder/subtractor with valid/ready
//             handshakes. Stage 1 registers the operands, stage 2 registers
//             the exact WIDTH+1-bit result and its overflow flag. A saturating
//             counter tracks delivered overflowed results.
//  Ports    : clk      - rising-edge clock
//             rst_n    - asynchronous active-low reset
//             bus      - signed_addsub_pipe_if.slave (operand/result channels)
//             cnt_clr  - synchronous clear of ovf_cnt (wins over increment)
//             ovf_cnt  - saturating count of delivered overflowed results
//  Options  : SIGNED_ADDSUB_SAT_EN adds bus.out_sat, the result clamped to
//             WIDTH bits, registered alongside out_sum.
//  Revision : 1.0 - initial release
// ============================================================================
module signed_addsub_pipe
    import signed_addsub_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    signed_addsub_pipe_if.slave  bus,
    input  logic                 cnt_clr,
    output logic [OVF_CNT_W-1:0] ovf_cnt
);

    localparam int S1_DW = 2 * WIDTH + 1;   // {op, a, b}
`ifdef SIGNED_ADDSUB_SAT_EN
    localparam int S2_DW = 2 * WIDTH + 2;   // {sum, ovf, sat}
    localparam logic [63:0]      SAT_MAX_FULL = sat_max(WIDTH);
    localparam logic [63:0]      SAT_MIN_FULL = sat_min(WIDTH);
    localparam logic [WIDTH-1:0] SAT_MAX      = SAT_MAX_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SAT_MIN      = SAT_MIN_FULL[WIDTH-1:0];
`else
    localparam int S2_DW = WIDTH + 2;       // {sum, ovf}
`endif
    localparam logic [OVF_CNT_W-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------
    // Stall control: a stage advances when it is empty or the stage after
    // it advances. in_ready depends only on state and out_ready.
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    // ------------------------------------------------------------------
    // Stage 1: operand register
    // ------------------------------------------------------------------
    logic [S1_DW-1:0] s1_in;
    logic [S1_DW-1:0] s1_data;

    assign s1_in = {bus.in_op, bus.in_a, bus.in_b};

    addsub_pipe_stage #(
        .DW (S1_DW)
    ) u_stage1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv       (s1_adv),
        .in_valid  (bus.in_valid),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_data  (s1_data)
    );

    // ------------------------------------------------------------------
    // Stage 2 arithmetic: sign-extend both operands by one bit so the
    // result is exact, including A - (-2^(WIDTH-1)).
    // ------------------------------------------------------------------
    logic             s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   sum_calc;
    logic             ovf_calc;
    logic [S2_DW-1:0] s2_in;
    logic [S2_DW-1:0] s2_data;

    assign s1_op = s1_data[2*WIDTH];
    assign s1_a  = s1_data[2*WIDTH-1:WIDTH];
    assign s1_b  = s1_data[WIDTH-1:0];
    assign a_ext = {s1_a[WIDTH-1], s1_a};
    assign b_ext = {s1_b[WIDTH-1], s1_b};

    always_comb begin
        if (s1_op == OP_SUB) begin
            sum_calc = a_ext - b_ext;
        end else begin
            sum_calc = a_ext + b_ext;
        end
    end

    // The result fits in WIDTH bits exactly when its top two bits agree.
    assign ovf_calc = sum_calc[WIDTH] ^ sum_calc[WIDTH-1];

`ifdef SIGNED_ADDSUB_SAT_EN
    logic [WIDTH-1:0] sat_calc;

    always_comb begin
        sat_calc = sum_calc[WIDTH-1:0];
        if (ovf_calc) begin
            // Bit WIDTH is the true sign of the exact result.
            sat_calc = sum_calc[WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end

    assign s2_in       = {sum_calc, ovf_calc, sat_calc};
    assign bus.out_sat = s2_data[WIDTH-1:0];
    assign bus.out_sum = s2_data[S2_DW-1 -: (WIDTH + 1)];
    assign bus.out_ovf = s2_data[WIDTH];
`else
    assign s2_in       = {sum_calc, ovf_calc};
    assign bus.out_sum = s2_data[S2_DW-1 -: (WIDTH + 1)];
    assign bus.out_ovf = s2_data[0];
`endif

    addsub_pipe_stage #(
        .DW (S2_DW)
    ) u_stage2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv       (s2_adv),
        .in_valid  (s1_valid),
        .in_data   (s2_in),
        .out_valid (s2_valid),
        .out_data  (s2_data)
    );

    assign bus.out_valid = s2_valid;

    // ------------------------------------------------------------------
    // Overflow event counter: counts delivered results only, saturates,
    // and a clear overrides a same-cycle increment.
    // ------------------------------------------------------------------
    logic                 out_xfer;
    logic [OVF_CNT_W-1:0] ovf_cnt_d;
    logic [OVF_CNT_W-1:0] ovf_cnt_q;

    assign out_xfer = s2_valid && bus.out_ready;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (cnt_clr) begin
            ovf_cnt_d = '0;
        end else if (out_xfer && bus.out_ovf && (ovf_cnt_q != CNT_MAX)) begin
            ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;

endmodule : signed_addsub_pipe
`default_nettype wire

// File: doc/signed_addsub_pipe.md
Name: signed_addsub_pipe

Overview:
Parametrised successor to the 4-bit signed adder: a 2-stage pipelined signed adder/subtractor of WIDTH-bit operands with valid/ready handshakes on input and output.
Produces the exact WIDTH+1-bit result plus an overflow flag, meaning the result does not fit in WIDTH bits.
Keeps a saturating count of overflowed results for datapath monitoring.
Sits between an operand source and any consumer that can apply backpressure.

Parameters:
WIDTH, 4, operand width in bits (two's complement), minimum 2
OVF_CNT_W, 8, width of the overflow event counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands and op presented
in_ready  out  1  block can accept operands this cycle
in_a  in  WIDTH  signed operand A
in_b  in  WIDTH  signed operand B
in_op  in  1  0 = A+B, 1 = A-B
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_sum  out  WIDTH+1  exact signed result
out_ovf  out  1  result outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]
ovf_cnt  out  OVF_CNT_W  count of accepted overflowed results
cnt_clr  in  1  synchronous clear of ovf_cnt

Behaviour:
- Reset (async assert, sync deassert at the block boundary): s1_valid=0, s2_valid=0, out_valid=0, out_sum=0, out_ovf=0, ovf_cnt=0. in_ready=1 once reset is released. Reset mid-operation discards all in-flight data.
- Input handshake: a transfer occurs when in_valid && in_ready.
- Output handshake: a transfer occurs when out_valid && out_ready.
- Stage 1 registers in_a, in_b, in_op and s1_valid.
- Stage 2 computes sext(a) ± sext(b) at WIDTH+1 bits and registers out_sum, out_ovf and s2_valid. out_valid = s2_valid.
- Latency: 2 cycles from accepted input to out_valid with no stall. Throughput is 1 result per cycle.
- Stall rules:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational from out_ready; no combinational path from in_valid)
  - A stage holds its contents when it cannot advance.
  - A bubble loads valid=0. Data registers of invalid stages are don't-care except out_sum/out_ovf, which hold their last value.
- Arithmetic:
  - out_ovf = (out_sum[WIDTH] != out_sum[WIDTH-1]).
  - Subtraction of -2^(WIDTH-1) is exact in WIDTH+1 bits; it never wraps.
- Counter:
  - Increments on each output transfer with out_ovf=1.
  - Saturates at 2^OVF_CNT_W-1.
  - cnt_clr forces 0 next cycle and wins over a simultaneous increment.
- Simultaneous input and output transfer with both stages full: the pipeline shifts, no data is lost or duplicated.
- out_valid, once asserted, stays asserted with stable out_sum/out_ovf until the output transfer.

Optional Feature:
Macro SIGNED_ADDSUB_SAT_EN.
- Defined: adds output out_sat[WIDTH-1:0], registered in stage 2.
  - Equals out_sum[WIDTH-1:0] when out_ovf=0.
  - Otherwise equals 2^(WIDTH-1)-1 if out_sum is positive, or -2^(WIDTH-1) if negative.
  - Reset value 0.
- Undefined: port and logic absent. All other behaviour is identical.

Decomposition:
- Package signed_addsub_pkg holds:
  - op encoding constants OP_ADD=1'b0, OP_SUB=1'b1
  - functions sat_max(width) and sat_min(width) used by the saturation logic
- One natural sub-module: addsub_pipe_stage, a single elastic register slice with valid, advance and data parameterised by DW. Instantiated twice.

Test Plan:
1. WIDTH=4, out_ready=1: (4,3,ADD) -> out_sum=7, ovf=0, exactly 2 cycles after acceptance. Then (7,2,ADD) -> 9, ovf=1, sat=7.
2. (-5,-4,ADD) -> -9, ovf=1, sat=-8. (-8,1,SUB) -> -9, ovf=1. (-8,-8,SUB) -> 0, ovf=0. (-3,2,ADD) -> -1, ovf=0.
3. Backpressure: stream 6 back-to-back inputs with out_ready=0 -> in_ready drops after 2 accepted. Output is held stable. Releasing out_ready delivers all 6 in order, no loss or duplicates.
4. Counter: 3 overflowed results accepted -> ovf_cnt=3. cnt_clr asserted in the same cycle as a 4th overflow transfer -> ovf_cnt=0. OVF_CNT_W=2 with 5 overflows -> holds at 3.
5. Reset mid-operation: rst_n pulsed low while both stages are valid -> out_valid=0 and ovf_cnt=0 immediately. No stale result appears after release.
6. Random signed operands over 10k transfers with random out_ready, compared against a reference model -> exact match of out_sum, out_ovf and out_sat.
